mac_soft_crc: RTL

//  Parametrised Ethernet CRC-32 engine for the 10GbE MAC data paths; vendor-primitive-free successor to the hard CRC wrapper.

---
 rtl/mac_crc_pkg.sv | 23 ++
 rtl/crc32_lane_step.sv | 33 +++
 rtl/mac_soft_crc.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mac_crc_pkg.sv
// Shared constants and the single-byte reflected CRC-32 step used by the MAC CRC engine.
package mac_crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } frame_state_e;

    // Byte enters LSB-first, matching Ethernet bit order on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] state, input logic [7:0] data);
        logic [31:0] s;
        s = state ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            s = s[0] ? ((s >> 1) ^ CRC32_POLY_REFL) : (s >> 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/crc32_lane_step.sv
// Combinational CRC-32 advance over the first nbytes_i bytes of a beat, byte 0 first.
module crc32_lane_step
    import mac_crc_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int CNT_W      = $clog2(DATA_BYTES + 1)
) (
    input  logic [31:0]             state_i,
    input  logic [8*DATA_BYTES-1:0] data_i,
    input  logic [CNT_W-1:0]        nbytes_i,
    output logic [31:0]             state_o
);

    logic [31:0] chain [DATA_BYTES+1];

    always_comb begin
        chain[0] = state_i;
        for (int k = 0; k < DATA_BYTES; k++) begin
            chain[k+1] = crc32_byte(chain[k], data_i[8*k +: 8]);
        end
    end

    // Tap the chain after exactly nbytes_i bytes; zero bytes passes the state through.
    always_comb begin
        state_o = chain[0];
        for (int k = 1; k <= DATA_BYTES; k++) begin
            if (nbytes_i == CNT_W'(k)) begin
                state_o = chain[k];
            end
        end
    end

endmodule

// File: rtl/mac_soft_crc.sv
// Ethernet CRC-32 engine: frames beats by SOF/EOF, accumulates CRC and length, reports per frame.
module mac_soft_crc
    import mac_crc_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int OUT_REG    = 0,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [8*DATA_BYTES-1:0] din_i,
    input  logic [DATA_BYTES-1:0]   din_valid_i,
    input  logic                    din_sof_i,
    input  logic                    din_eof_i,
    output logic [31:0]             crc_out_o,
    output logic                    crc_valid_o,
    output logic                    crc_ok_o,
    output logic                    mask_err_o,
    output logic [LEN_WIDTH-1:0]    frame_len_o
);

    localparam int CNT_W = $clog2(DATA_BYTES + 1);

    frame_state_e         fsm_q;
    logic [31:0]          state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 err_q;

    logic [31:0]          state_d;
    logic [LEN_WIDTH-1:0] len_d;
    logic                 err_d;

    logic                 res_valid_q;
    logic [31:0]          res_crc_q;
    logic                 res_ok_q;
    logic                 res_err_q;
    logic [LEN_WIDTH-1:0] res_len_q;

    logic [CNT_W-1:0]     nBytes;
    logic                 leadRun;
    logic                 maskOk;
    logic                 sofQual;
    logic                 take;
    logic                 report;
    logic [31:0]          baseState;
    logic [LEN_WIDTH-1:0] baseLen;
    logic                 baseErr;
    logic [LEN_WIDTH:0]   lenSum;

    // Only the run of ones starting at byte 0 carries data.
    always_comb begin
        nBytes  = '0;
        leadRun = 1'b1;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (leadRun && din_valid_i[i]) begin
                nBytes = nBytes + CNT_W'(1);
            end else begin
                leadRun = 1'b0;
            end
        end
    end

    assign maskOk = ((din_valid_i & (din_valid_i + DATA_BYTES'(1))) == '0);

    // An empty SOF beat only opens a frame if it also closes it.
    assign sofQual   = din_sof_i && ((|din_valid_i) || din_eof_i);
    assign take      = sofQual || (fsm_q == ST_FRAME);
    assign report    = take && din_eof_i;
    assign baseState = sofQual ? CRC32_INIT : state_q;
    assign baseLen   = sofQual ? '0 : len_q;
    assign baseErr   = sofQual ? 1'b0 : err_q;

    assign lenSum = {1'b0, baseLen} + (LEN_WIDTH+1)'(nBytes);
    assign len_d  = lenSum[LEN_WIDTH] ? '1 : lenSum[LEN_WIDTH-1:0];
    assign err_d  = baseErr | ~maskOk;

    crc32_lane_step #(
        .DATA_BYTES (DATA_BYTES),
        .CNT_W      (CNT_W)
    ) u_lane_step (
        .state_i  (baseState),
        .data_i   (din_i),
        .nbytes_i (nBytes),
        .state_o  (state_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= ST_IDLE;
            state_q     <= CRC32_INIT;
            len_q       <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_crc_q   <= '0;
            res_ok_q    <= 1'b0;
            res_err_q   <= 1'b0;
            res_len_q   <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE:  if (sofQual && !din_eof_i) fsm_q <= ST_FRAME;
                ST_FRAME: if (din_eof_i) fsm_q <= ST_IDLE;
                default:  fsm_q <= ST_IDLE;
            endcase

            res_valid_q <= report;
            if (report) begin
                res_crc_q <= ~state_d;
                res_ok_q  <= (state_d == CRC32_RESIDUE);
                res_err_q <= err_d;
                res_len_q <= len_d;
                state_q   <= CRC32_INIT;
                len_q     <= '0;
                err_q     <= 1'b0;
            end else if (take) begin
                state_q <= state_d;
                len_q   <= len_d;
                err_q   <= err_d;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                 out_valid_q;
            logic [31:0]          out_crc_q;
            logic                 out_ok_q;
            logic                 out_err_q;
            logic [LEN_WIDTH-1:0] out_len_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    out_valid_q <= 1'b0;
                    out_crc_q   <= '0;
                    out_ok_q    <= 1'b0;
                    out_err_q   <= 1'b0;
                    out_len_q   <= '0;
                end else begin
                    out_valid_q <= res_valid_q;
                    if (res_valid_q) begin
                        out_crc_q <= res_crc_q;
                        out_ok_q  <= res_ok_q;
                        out_err_q <= res_err_q;
                        out_len_q <= res_len_q;
                    end
                end
            end

            assign crc_valid_o = out_valid_q;
            assign crc_out_o   = out_crc_q;
            assign crc_ok_o    = out_ok_q;
            assign mask_err_o  = out_err_q;
            assign frame_len_o = out_len_q;
        end else begin : g_no_out_reg
            assign crc_valid_o = res_valid_q;
            assign crc_out_o   = res_crc_q;
            assign crc_ok_o    = res_ok_q;
            assign mask_err_o  = res_err_q;
            assign frame_len_o = res_len_q;
        end
    endgenerate

endmodule
